// File: rtl/dp_sequencer.sv
// dp_sequencer
// Fetch/decode/write sequencer that drives the DataPath register-file write
// port (irInput, dataInput, wEn, registerFileSelect) from a program held in an
// instruction memory reached over a req/ack handshake.
// Optional feature macro: DPS_SINGLE_STEP_EN adds a 'step' input; the FSM then
// parks in PAUSE before every instruction fetch until 'step' is seen.
// All outputs are driven straight from registers.

module dp_sequencer #(
    parameter int WIDTH  = 32,
    parameter int AW     = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DPS_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] irInput,
    output logic [WIDTH-1:0] dataInput,
    output logic             wEn,
    output logic             registerFileSelect,
    output logic             busy,
    output logic             halted,
    output logic             err
);

    // Settle counter runs 0 .. SETTLE-1 while in SETUP.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FETCHD = 3'd3,
        S_SETUP  = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6,
        S_PAUSE  = 3'd7
    } state_t;

    // State entered before every instruction (not literal) fetch, and the
    // value imem_req must take on that entry.
`ifdef DPS_SINGLE_STEP_EN
    localparam state_t INSTR_ENTRY = S_PAUSE;
    localparam logic   ENTRY_REQ   = 1'b0;
`else
    localparam state_t INSTR_ENTRY = S_FETCH;
    localparam logic   ENTRY_REQ   = 1'b1;
`endif

    // Legal ALU opcodes: 0000, 0001 and 1000 through 1110.
    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001,
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1110: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    endfunction

    state_t           state_r;
    logic [AW-1:0]    pc_r;
    logic [WIDTH-1:0] ir_r;
    logic [WIDTH-1:0] ir_out_r;
    logic [WIDTH-1:0] data_r;
    logic             req_r;
    logic             wen_r;
    logic             sel_r;
    logic             busy_r;
    logic             halted_r;
    logic             err_r;
    logic [CW-1:0]    cnt_r;

    logic             is_halt_s;
    logic             is_ldw_s;
    logic             is_legal_s;
    logic             fetch_done_s;

    // Classify the latched instruction word and qualify the fetch handshake.
    always_comb begin
        is_halt_s    = (ir_r == {WIDTH{1'b1}});
        is_ldw_s     = ir_r[31];
        is_legal_s   = op_legal(ir_r[29:26]);
        fetch_done_s = req_r & imem_ack;
    end

    // Sequencer FSM; every output is assigned here so all of them are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            pc_r     <= '0;
            ir_r     <= '0;
            ir_out_r <= '0;
            data_r   <= '0;
            req_r    <= 1'b0;
            wen_r    <= 1'b0;
            sel_r    <= 1'b0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            cnt_r    <= '0;
        end else begin
            // wEn is a single-cycle pulse; only SETUP->WRITE raises it.
            wen_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        pc_r    <= '0;
                        busy_r  <= 1'b1;
                        req_r   <= ENTRY_REQ;
                        state_r <= INSTR_ENTRY;
                    end
                end
                S_FETCH: begin
                    if (fetch_done_s) begin
                        ir_r    <= imem_rdata;
                        pc_r    <= pc_r + AW'(1);
                        req_r   <= 1'b0;
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt_s) begin
                        halted_r <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_HALT;
                    end else if (is_ldw_s) begin
                        req_r    <= 1'b1;
                        state_r  <= S_FETCHD;
                    end else if (!is_legal_s) begin
                        err_r    <= 1'b1;
                        req_r    <= ENTRY_REQ;
                        state_r  <= INSTR_ENTRY;
                    end else begin
                        ir_out_r <= ir_r;
                        sel_r    <= 1'b0;
                        cnt_r    <= '0;
                        state_r  <= S_SETUP;
                    end
                end
                S_FETCHD: begin
                    // Literal word follows the LDW; PC wraps naturally at 2^AW.
                    if (fetch_done_s) begin
                        data_r   <= imem_rdata;
                        pc_r     <= pc_r + AW'(1);
                        req_r    <= 1'b0;
                        ir_out_r <= ir_r;
                        sel_r    <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Hold irInput/dataInput/sel for SETTLE cycles so the ALU settles.
                    if (cnt_r == SETTLE_LAST) begin
                        wen_r   <= 1'b1;
                        state_r <= S_WRITE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                S_WRITE: begin
                    req_r   <= ENTRY_REQ;
                    state_r <= INSTR_ENTRY;
                end
                S_HALT: begin
                    if (start) begin
                        halted_r <= 1'b0;
                        busy_r   <= 1'b1;
                        pc_r     <= '0;
                        req_r    <= ENTRY_REQ;
                        state_r  <= INSTR_ENTRY;
                    end
                end
`ifdef DPS_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        req_r   <= 1'b1;
                        state_r <= S_FETCH;
                    end
                end
`endif
                default: begin
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req           = req_r;
    assign imem_addr          = pc_r;
    assign irInput            = ir_out_r;
    assign dataInput          = data_r;
    assign wEn                = wen_r;
    assign registerFileSelect = sel_r;
    assign busy               = busy_r;
    assign halted             = halted_r;
    assign err                = err_r;

endmodule

// File: tb/tb_dp_sequencer.sv
// Testbench for dp_sequencer: an instruction-memory responder, a small DataPath
// register-file model fed by the observed write pulses, and a program-level
// reference model that walks the instruction memory to predict the writes.
`timescale 1ns/1ps

module tb_dp_sequencer;

    localparam int          AW     = 8;
    localparam int          AW2    = 2;
    localparam int          SETTLE = 2;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] data;
        logic        sel;
        int          stable;
        int          cyc;
    } pulse_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   irInput, dataInput;
    logic          wEn, registerFileSelect, busy, halted, err;

    logic           start2 = 1'b0;
    logic           imem_ack2;
    logic [31:0]    imem_rdata2;
    logic           imem_req2;
    logic [AW2-1:0] imem_addr2;
    logic [31:0]    irInput2, dataInput2;
    logic           wEn2, registerFileSelect2, busy2, halted2, err2;

`ifdef DPS_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    dp_sequencer #(.WIDTH(32), .AW(AW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DPS_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .irInput(irInput), .dataInput(dataInput),
        .wEn(wEn), .registerFileSelect(registerFileSelect), .busy(busy),
        .halted(halted), .err(err)
    );

    dp_sequencer #(.WIDTH(32), .AW(AW2), .SETTLE(SETTLE)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef DPS_SINGLE_STEP_EN
        .step(step),
`endif
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
        .imem_rdata(imem_rdata2), .irInput(irInput2), .dataInput(dataInput2),
        .wEn(wEn2), .registerFileSelect(registerFileSelect2), .busy(busy2),
        .halted(halted2), .err(err2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [4];
    logic [31:0] regs [32];

    pulse_t      pulses[$];
    pulse_t      exp_q[$];
    int          req_cycs[$];
    int          ack_cycs[$];
    logic [31:0] pulses2[$];
    int          fetch2[$];

    int wide_cnt, addr_moves, req_drops;
    bit rand_delay, stray_en;
    int fixed_delay;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction encodings used by the bench's DataPath model.
    function automatic logic [31:0] ldw(input logic [4:0] rc);
        return {1'b1, 5'b00000, rc, 21'd0};
    endfunction

    function automatic logic [31:0] alu(input logic lit, input logic [3:0] op,
                                        input logic [4:0] rc, input logic [4:0] ra,
                                        input logic [15:0] low);
        return {1'b0, lit, op, rc, ra, low};
    endfunction

    function automatic bit legal_op(input logic [3:0] op);
        return (op <= 4'd1) || (op >= 4'd8 && op <= 4'd14);
    endfunction

    function automatic logic [31:0] dp_alu(input logic [31:0] ir);
        logic [31:0] a, b;
        a = regs[ir[20:16]];
        b = ir[30] ? {{16{ir[15]}}, ir[15:0]} : regs[ir[15:11]];
        case (ir[29:26])
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            default: return b;
        endcase
    endfunction

    // Monitor + memory responder for the main DUT (one process: monitor first).
    initial begin
        int          req_cnt, this_delay, stable;
        logic [31:0] last_ir;
        logic        prev_wen, prev_req, prev_ack;
        logic [AW-1:0] prev_addr;
        req_cnt = 0; this_delay = 0; stable = 0; last_ir = '0;
        prev_wen = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (irInput !== last_ir) stable = 0; else stable++;
            last_ir = irInput;
            if (wEn) begin
                if (prev_wen) wide_cnt++;
                pulses.push_back('{irInput, dataInput, registerFileSelect, stable, cyc});
                regs[irInput[25:21]] = registerFileSelect ? dataInput : dp_alu(irInput);
            end
            if (imem_req && prev_req && imem_addr !== prev_addr) addr_moves++;
            if (prev_req && !imem_req && !prev_ack && rst_n) req_drops++;
            prev_wen = wEn; prev_req = imem_req; prev_addr = imem_addr;
            if (imem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    req_cycs.push_back(cyc);
                    this_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
                end
                if (req_cnt > this_delay) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[imem_addr];
                    ack_cycs.push_back(cyc);
                    req_cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                req_cnt = 0;
                imem_ack = stray_en && ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
            prev_ack = imem_ack;
        end
    end

    // Zero-wait responder and monitor for the AW=2 instance.
    initial begin
        imem_ack2 = 1'b0; imem_rdata2 = '0;
        forever begin
            @(negedge clk);
            if (wEn2) pulses2.push_back(irInput2);
            if (imem_req2) begin
                imem_ack2 = 1'b1;
                imem_rdata2 = mem2[imem_addr2];
                fetch2.push_back(int'(imem_addr2));
            end else begin
                imem_ack2 = 1'b0;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        pulses.delete(); req_cycs.delete(); ack_cycs.delete();
        pulses2.delete(); fetch2.delete();
        foreach (regs[i]) regs[i] = '0;
        wide_cnt = 0; addr_moves = 0; req_drops = 0;
        rand_delay = 1'b0; stray_en = 1'b0; fixed_delay = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_halt;
        foreach (mem[i]) mem[i] = HALT_W;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    // Program-level prediction: walk memory from address 0 until HALT.
    task automatic model_program(output bit exp_err, output bit exp_halt);
        int pc;
        logic [31:0] w, data;
        exp_q.delete(); exp_err = 1'b0; exp_halt = 1'b0; pc = 0; data = '0;
        for (int n = 0; n < 200 && !exp_halt; n++) begin
            w = mem[pc]; pc = (pc + 1) % 256;
            if (w == HALT_W) exp_halt = 1'b1;
            else if (w[31]) begin
                data = mem[pc]; pc = (pc + 1) % 256;
                exp_q.push_back('{w, data, 1'b1, 0, 0});
            end else if (legal_op(w[29:26])) exp_q.push_back('{w, data, 1'b0, 0, 0});
            else exp_err = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit seen;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, irInput, dataInput, wEn, registerFileSelect, busy, halted, err} !== '0) begin
            errors++; $display("FAIL reset_state: outputs not all zero (busy=%0b req=%0b)", busy, imem_req);
        end
        do_reset;
        fill_halt; mem[0] = ldw(5'd4); mem[1] = 32'h4;
        pulse_start;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wEn) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_wen_seen: got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wEn !== 1'b0) begin errors++; $display("FAIL reset_mid_write_wen: got %0b want 0", wEn); end
        checks++;
        if ({imem_req, imem_addr, irInput, dataInput, registerFileSelect, busy, halted, err} !== '0) begin
            errors++; $display("FAIL reset_mid_write_outputs: ir=%h data=%h busy=%0b", irInput, dataInput, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({busy, imem_req, wEn, halted} !== 4'b0000) begin
            errors++; $display("FAIL reset_idle: busy/req/wen/halted got %b want 0000", {busy, imem_req, wEn, halted});
        end
    endtask

    task automatic test_program;
        bit ok;
        do_reset; fill_halt;
        mem[0] = ldw(5'd4);  mem[1] = 32'h4;
        mem[2] = ldw(5'd7);  mem[3] = 32'h7;
        mem[4] = alu(1'b0, 4'b0000, 5'd11, 5'd4, {5'd7, 11'd0});
        pulse_pulse_start_wrap();
        wait_halt(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL prog_halt: halted got %0b want 1", halted); end
        checks++;
        if (pulses.size() != 3) begin
            errors++; $display("FAIL prog_pulse_count: got %0d want 3", pulses.size());
        end else begin
            checks++;
            if ({pulses[0].sel, pulses[1].sel, pulses[2].sel} !== 3'b110) begin
                errors++; $display("FAIL prog_sel_seq: got %b want 110", {pulses[0].sel, pulses[1].sel, pulses[2].sel});
            end
        end
        checks++;
        if (regs[11] !== 32'hB) begin errors++; $display("FAIL prog_r11: got %h want 0000000b", regs[11]); end
        checks++;
        if (wide_cnt != 0) begin errors++; $display("FAIL prog_pulse_width: %0d wide pulses want 0", wide_cnt); end
        checks++;
        if ({busy, err} !== 2'b00) begin errors++; $display("FAIL prog_busy_err: got %b want 00", {busy, err}); end
    endtask

    task automatic pulse_pulse_start_wrap;
        pulse_start;
    endtask

    task automatic test_literal;
        bit ok;
        do_reset; fill_halt;
        mem[0] = ldw(5'd4); mem[1] = 32'h4;
        mem[2] = alu(1'b1, 4'b0000, 5'd30, 5'd4, 16'hFF00);
        pulse_start;
        wait_halt(300, ok);
        checks++;
        if (regs[30] !== 32'hFFFF_FF04) begin errors++; $display("FAIL lit_r30: got %h want ffffff04", regs[30]); end
        checks++;
        if (pulses.size() != 2) begin
            errors++; $display("FAIL lit_count: got %0d want 2", pulses.size());
        end else begin
            checks++;
            if (pulses[1].ir !== mem[2] || pulses[1].stable < SETTLE) begin
                errors++; $display("FAIL lit_ir_stable: ir %h stable %0d want %h stable>=%0d",
                                   pulses[1].ir, pulses[1].stable, mem[2], SETTLE);
            end
        end
    endtask

    task automatic test_ack_delay;
        bit ok;
        do_reset; fill_halt; fixed_delay = 5;
        mem[0] = alu(1'b0, 4'b0000, 5'd1, 5'd0, 16'd0);
        pulse_start;
        wait_halt(300, ok);
        checks++;
        if (!ok || pulses.size() != 1 || req_cycs.size() < 1 || ack_cycs.size() < 1) begin
            errors++; $display("FAIL delay_run: halted %0b pulses %0d want 1 1", halted, pulses.size());
        end else begin
            checks++;
            if (ack_cycs[0] - req_cycs[0] != 5) begin
                errors++; $display("FAIL delay_req_held: got %0d cycles want 5", ack_cycs[0] - req_cycs[0]);
            end
            checks++;
            if (pulses[0].cyc - ack_cycs[0] != SETTLE + 2) begin
                errors++; $display("FAIL delay_wen_latency: got %0d want %0d", pulses[0].cyc - ack_cycs[0], SETTLE + 2);
            end
        end
        checks++;
        if (addr_moves != 0 || req_drops != 0) begin
            errors++; $display("FAIL delay_req_stable: addr moves %0d req drops %0d want 0 0", addr_moves, req_drops);
        end
    endtask

    task automatic test_illegal;
        bit ok;
        do_reset; fill_halt;
        mem[0] = alu(1'b0, 4'b0101, 5'd3, 5'd1, 16'h1234);
        pulse_start;
        wait_halt(300, ok);
        checks++;
        if ({ok, err} !== 2'b11 || pulses.size() != 0) begin
            errors++; $display("FAIL illegal_op: halted %0b err %0b pulses %0d want 1 1 0", ok, err, pulses.size());
        end
    endtask

    task automatic test_random;
        bit ok, exp_err, exp_halt;
        int idx, n, k, nmin;
        for (int it = 0; it < 20; it++) begin
            do_reset; fill_halt;
            rand_delay = 1'b1; stray_en = 1'b1;
            idx = 0; n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                k = $urandom_range(0, 9);
                if (k < 3) begin
                    mem[idx] = ldw(5'($urandom)); mem[idx + 1] = $urandom; idx += 2;
                end else if (k < 8) begin
                    k = $urandom_range(0, 8);
                    mem[idx] = alu(1'($urandom), (k < 2) ? 4'(k) : 4'(k + 6), 5'($urandom), 5'($urandom), 16'($urandom));
                    idx++;
                end else begin
                    k = $urandom_range(0, 6);
                    mem[idx] = alu(1'($urandom), (k < 6) ? 4'(k + 2) : 4'd15, 5'($urandom), 5'($urandom), 16'($urandom));
                    idx++;
                end
            end
            model_program(exp_err, exp_halt);
            pulse_start;
            wait_halt(1000, ok);
            checks++;
            if (ok != exp_halt || err !== exp_err) begin
                errors++; $display("FAIL rnd_status[%0d]: halted %0b err %0b want %0b %0b", it, ok, err, exp_halt, exp_err);
            end
            checks++;
            if (pulses.size() != exp_q.size()) begin
                errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", it, pulses.size(), exp_q.size());
            end
            nmin = (pulses.size() < exp_q.size()) ? pulses.size() : exp_q.size();
            for (int i = 0; i < nmin; i++) begin
                checks++;
                if (pulses[i].ir !== exp_q[i].ir || pulses[i].data !== exp_q[i].data ||
                    pulses[i].sel !== exp_q[i].sel || pulses[i].stable < SETTLE) begin
                    errors++;
                    $display("FAIL rnd_write[%0d.%0d]: ir %h data %h sel %0b stable %0d want %h %h %0b >=%0d",
                             it, i, pulses[i].ir, pulses[i].data, pulses[i].sel, pulses[i].stable,
                             exp_q[i].ir, exp_q[i].data, exp_q[i].sel, SETTLE);
                end
            end
            checks++;
            if (wide_cnt != 0 || addr_moves != 0 || req_drops != 0) begin
                errors++; $display("FAIL rnd_protocol[%0d]: wide %0d moves %0d drops %0d want 0 0 0",
                                   it, wide_cnt, addr_moves, req_drops);
            end
        end
    endtask

    task automatic test_wrap;
        bit ok;
        do_reset;
        for (int i = 0; i < 4; i++) mem2[i] = alu(1'b0, 4'b0000, 5'(i + 1), 5'd0, 16'd0);
        @(negedge clk); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulses2.size() >= 6) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL wrap_progress: got %0d pulses want 6", pulses2.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pulses2[i] !== mem2[i % 4] || fetch2[i] != i % 4) begin
                    errors++; $display("FAIL wrap_seq[%0d]: ir %h addr %0d want %h %0d",
                                       i, pulses2[i], fetch2[i], mem2[i % 4], i % 4);
                end
            end
        end
        do_reset;
        mem2[2] = HALT_W;
        @(negedge clk); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (halted2) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || busy2 !== 1'b0) begin errors++; $display("FAIL wrap_halt: halted %0b busy %0b want 1 0", ok, busy2); end
        pulses2.delete(); fetch2.delete();
        @(negedge clk); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulses2.size() >= 1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || fetch2.size() < 1) begin
            errors++; $display("FAIL restart_progress: got %0d pulses want 1", pulses2.size());
        end else if (fetch2[0] != 0 || pulses2[0] !== mem2[0]) begin
            errors++; $display("FAIL restart_addr: addr %0d ir %h want 0 %h", fetch2[0], pulses2[0], mem2[0]);
        end
    endtask

    initial begin
        test_reset;
        test_program;
        test_literal;
        test_ack_delay;
        test_illegal;
        test_random;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
